// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified I/D memory port: FSM encoding and handshake widths,
// kept here so the hazard unit and the memory model agree with the arbiter.
package mem_port_arbiter_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_D = 2'b01,
    BUSY_I = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (F) and memory stage (M),
// data first, and raises the per-stage stall requests consumed by the hazard unit.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InstrReqF,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] InstrF,
  output logic              InstrValidF,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              MemDoneM,
  output logic              StallIF,
  output logic              StallMEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t state;

  // A requester whose done/valid pulse is high has not advanced its stage yet,
  // so it is neither stalled nor re-granted this cycle.
  assign StallIF  = InstrReqF & ~InstrValidF;
  assign StallMEM = MemReqM & ~MemDoneM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      InstrF      <= '0;
      ReadDataM   <= '0;
      InstrValidF <= 1'b0;
      MemDoneM    <= 1'b0;
    end else begin
      InstrValidF <= 1'b0;
      MemDoneM    <= 1'b0;
      case (state)
        IDLE: begin
          if (StallMEM) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ALUOutM;
            mem_wdata <= WriteDataM;
          end else if (StallIF) begin
            state    <= BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= PCF;
          end else begin
            mem_req <= 1'b0;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            if (!mem_we) ReadDataM <= mem_rdata;
            MemDoneM <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            // A redirect during the access drops the stale instruction; fetch re-arbitrates.
            if (PCF == mem_addr) begin
              InstrF      <= mem_rdata;
              InstrValidF <= 1'b1;
            end
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, contention, slow store, redirect, reset mid-access.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        InstrReqF;
  logic [31:0] PCF;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic [31:0] ReadDataM;
  logic        MemDoneM;
  logic        StallIF;
  logic        StallMEM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .InstrReqF(InstrReqF), .PCF(PCF),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .InstrF(InstrF), .InstrValidF(InstrValidF),
    .ReadDataM(ReadDataM), .MemDoneM(MemDoneM),
    .StallIF(StallIF), .StallMEM(StallMEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Registered outputs are sampled 1 time unit after the edge; inputs are driven right then.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; InstrReqF = 1'b0; PCF = '0; MemReqM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0; mem_rdata = 32'hFFFF_FFFF; mem_ack = 1'b1;

    // Reset with a spurious ack, then an ack in IDLE
    tick(); tick();
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_instr", InstrF, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_ivalid", 32'(InstrValidF), 32'd0);
    chk("rst_done", 32'(MemDoneM), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ack_rdata", ReadDataM, 32'h0);
    chk("idle_ack_instr", InstrF, 32'h0);
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    tick();

    // Zero-wait fetch
    InstrReqF = 1'b1; PCF = 32'h40;
    #1 chk("f0_stallif", 32'(StallIF), 32'd1);
    tick();
    chk("f1_req", 32'(mem_req), 32'd1);
    chk("f1_addr", mem_addr, 32'h40);
    chk("f1_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
    #1 chk("f1_stallif", 32'(StallIF), 32'd1);
    tick();
    chk("f2_ivalid", 32'(InstrValidF), 32'd1);
    chk("f2_instr", InstrF, 32'h8C22_0004);
    chk("f2_req", 32'(mem_req), 32'd0);
    chk("f2_stallif", 32'(StallIF), 32'd0);
    mem_ack = 1'b0; InstrReqF = 1'b0;
    tick();
    chk("f3_ivalid", 32'(InstrValidF), 32'd0);
    chk("f3_req", 32'(mem_req), 32'd0);

    // Contention: load first, then fetch
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h100; InstrReqF = 1'b1; PCF = 32'h44;
    tick();
    chk("c1_req", 32'(mem_req), 32'd1);
    chk("c1_addr", mem_addr, 32'h100);
    chk("c1_we", 32'(mem_we), 32'd0);
    chk("c1_stallmem", 32'(StallMEM), 32'd1);
    chk("c1_stallif", 32'(StallIF), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("c2_done", 32'(MemDoneM), 32'd1);
    chk("c2_rdata", ReadDataM, 32'hDEAD_BEEF);
    chk("c2_req", 32'(mem_req), 32'd0);
    chk("c2_stallmem", 32'(StallMEM), 32'd0);
    mem_ack = 1'b0; MemReqM = 1'b0;
    tick();
    chk("c3_req", 32'(mem_req), 32'd1);
    chk("c3_addr", mem_addr, 32'h44);
    chk("c3_done", 32'(MemDoneM), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0043_0020;
    tick();
    chk("c4_ivalid", 32'(InstrValidF), 32'd1);
    chk("c4_instr", InstrF, 32'h0043_0020);
    mem_ack = 1'b0; InstrReqF = 1'b0;
    tick();

    // Store, ack three cycles after mem_req rises
    MemReqM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h200; WriteDataM = 32'h1234_5678;
    mem_rdata = 32'hBAD0_BAD0;
    stall_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (StallMEM) stall_cnt++;
      if (c >= 1) begin
        chk($sformatf("s%0d_req", c), 32'(mem_req), 32'd1);
        chk($sformatf("s%0d_we", c), 32'(mem_we), 32'd1);
        chk($sformatf("s%0d_addr", c), mem_addr, 32'h200);
        chk($sformatf("s%0d_wdata", c), mem_wdata, 32'h1234_5678);
        chk($sformatf("s%0d_done", c), 32'(MemDoneM), 32'd0);
      end
      mem_ack = (c == 4);
      tick();
    end
    chk("s5_done", 32'(MemDoneM), 32'd1);
    chk("s5_rdata", ReadDataM, 32'hDEAD_BEEF);
    chk("s5_req", 32'(mem_req), 32'd0);
    chk("s5_stallmem", 32'(StallMEM), 32'd0);
    chk("s_stall_cycles", 32'(stall_cnt), 32'd5);
    mem_ack = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0;
    tick();

    // Branch redirect during fetch
    InstrReqF = 1'b1; PCF = 32'h48;
    tick();
    chk("r1_req", 32'(mem_req), 32'd1);
    chk("r1_addr", mem_addr, 32'h48);
    PCF = 32'h80;
    tick();
    chk("r2_addr", mem_addr, 32'h48);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    chk("r3_ivalid", 32'(InstrValidF), 32'd0);
    chk("r3_instr", InstrF, 32'h0043_0020);
    chk("r3_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    tick();
    chk("r4_req", 32'(mem_req), 32'd1);
    chk("r4_addr", mem_addr, 32'h80);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    chk("r5_ivalid", 32'(InstrValidF), 32'd1);
    chk("r5_instr", InstrF, 32'h2222_2222);
    mem_ack = 1'b0; InstrReqF = 1'b0;
    tick();

    // Reset while a load is outstanding
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h300;
    tick();
    chk("x1_req", 32'(mem_req), 32'd1);
    chk("x1_addr", mem_addr, 32'h300);
    rst = 1'b1;
    tick();
    chk("x2_req", 32'(mem_req), 32'd0);
    chk("x2_done", 32'(MemDoneM), 32'd0);
    chk("x2_rdata", ReadDataM, 32'h0);
    chk("x2_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0; MemReqM = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    chk("x3_done", 32'(MemDoneM), 32'd0);
    chk("x3_rdata", ReadDataM, 32'h0);
    chk("x3_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    tick();
    chk("x4_done", 32'(MemDoneM), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
